// File: rtl/as_mac_lut.sv
// Anti-spoof source-MAC table: linear-scan lookup plus register-block read/write handshakes.
// Optional build macro AS_MAC_LUT_PORT_CHECK_EN also requires the ingress port to be in the entry's oq.
module as_mac_lut #(
    parameter int NUM_OUTPUT_QUEUES = 5,
    parameter int LUT_DEPTH_BITS    = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         lookup_req,
    input  logic [47:0]                  lookup_mac,
    input  logic [NUM_OUTPUT_QUEUES-1:0] lookup_src_port,
    output logic                         lookup_ready,
    output logic                         lookup_done,
    output logic                         lookup_hit,
    output logic [NUM_OUTPUT_QUEUES-1:0] lookup_oq,
    output logic                         lut_hit,
    output logic                         lut_miss,
    input  logic [LUT_DEPTH_BITS-1:0]    rd_addr,
    input  logic                         rd_req,
    output logic                         rd_ack,
    output logic [NUM_OUTPUT_QUEUES-1:0] rd_oq,
    output logic                         rd_wr_protect,
    output logic [47:0]                  rd_mac,
    input  logic [LUT_DEPTH_BITS-1:0]    wr_addr,
    input  logic                         wr_req,
    output logic                         wr_ack,
    input  logic [NUM_OUTPUT_QUEUES-1:0] wr_oq,
    input  logic                         wr_protect,
    input  logic [47:0]                  wr_mac
);

    localparam int DEPTH = 2 ** LUT_DEPTH_BITS;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SCAN    = 2'd1;
    localparam logic [1:0] REG_ACK = 2'd2;

    logic [47:0]                  mac_tbl  [DEPTH];
    logic [NUM_OUTPUT_QUEUES-1:0] oq_tbl   [DEPTH];
    logic                         prot_tbl [DEPTH];

    logic [1:0]                   state;
    logic [LUT_DEPTH_BITS-1:0]    idx;
    logic [47:0]                  cap_mac;
    logic                         active;
    logic                         idle_free;
    logic                         mac_match;
    logic                         port_ok;

    // A zero search key can never match: empty entries hold mac 0.
    assign mac_match = (cap_mac != 48'h0) && (mac_tbl[idx] == cap_mac);

`ifdef AS_MAC_LUT_PORT_CHECK_EN
    logic [NUM_OUTPUT_QUEUES-1:0] cap_port;
    assign port_ok = |(oq_tbl[idx] & cap_port);
`else
    logic unused_src_port;
    assign unused_src_port = ^lookup_src_port;
    assign port_ok         = 1'b1;
`endif

    // The done cycle is still owned by the finishing lookup, so IDLE work starts one cycle later.
    assign idle_free    = (state == IDLE) && active && !lookup_done;
    assign lookup_ready = idle_free && !rd_req && !wr_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the table is cleared by reset, so it is a flop array rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mac_tbl[i]  <= '0;
                oq_tbl[i]   <= '0;
                prot_tbl[i] <= 1'b0;
            end
            state         <= IDLE;
            idx           <= '0;
            cap_mac       <= '0;
`ifdef AS_MAC_LUT_PORT_CHECK_EN
            cap_port      <= '0;
`endif
            active        <= 1'b0;
            lookup_done   <= 1'b0;
            lookup_hit    <= 1'b0;
            lookup_oq     <= '0;
            lut_hit       <= 1'b0;
            lut_miss      <= 1'b0;
            rd_ack        <= 1'b0;
            rd_oq         <= '0;
            rd_wr_protect <= 1'b0;
            rd_mac        <= '0;
            wr_ack        <= 1'b0;
        end else begin
            active      <= 1'b1;
            lookup_done <= 1'b0;
            lookup_hit  <= 1'b0;
            lookup_oq   <= '0;
            lut_hit     <= 1'b0;
            lut_miss    <= 1'b0;
            case (state)
                IDLE: begin
                    if (idle_free) begin
                        if (wr_req) begin
                            mac_tbl[wr_addr]  <= wr_mac;
                            oq_tbl[wr_addr]   <= wr_oq;
                            prot_tbl[wr_addr] <= wr_protect;
                            wr_ack            <= 1'b1;
                            state             <= REG_ACK;
                        end else if (rd_req) begin
                            rd_mac        <= mac_tbl[rd_addr];
                            rd_oq         <= oq_tbl[rd_addr];
                            rd_wr_protect <= prot_tbl[rd_addr];
                            rd_ack        <= 1'b1;
                            state         <= REG_ACK;
                        end else if (lookup_req) begin
                            cap_mac  <= lookup_mac;
`ifdef AS_MAC_LUT_PORT_CHECK_EN
                            cap_port <= lookup_src_port;
`endif
                            idx      <= '0;
                            state    <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    // Stop at the first MAC match even if the port check rejects it.
                    if (mac_match || (&idx)) begin
                        lookup_done <= 1'b1;
                        lookup_hit  <= mac_match && port_ok;
                        lut_hit     <= mac_match && port_ok;
                        lut_miss    <= !(mac_match && port_ok);
                        lookup_oq   <= mac_match ? oq_tbl[idx] : '0;
                        state       <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                REG_ACK: begin
                    if ((wr_ack && !wr_req) || (rd_ack && !rd_req)) begin
                        wr_ack        <= 1'b0;
                        rd_ack        <= 1'b0;
                        rd_mac        <= '0;
                        rd_oq         <= '0;
                        rd_wr_protect <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
